// File: rtl/pt_write_port.sv
// pt_write_port: buffers pixels from projective_transform in a small FIFO and
// drains them to a 36-bit word memory through a request/grant arbiter slot.
// Horizontally adjacent pixel pairs (even x, then x+1 on the same row) that
// are both queued when a write is prepared are packed into one full word.
module pt_write_port #(
  parameter int DEPTH    = 4,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [17:0] pt_pixel_write,
  input  logic [9:0]  pt_x,
  input  logic [8:0]  pt_y,
  input  logic        pt_wr,
  output logic        ptflag,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [18:0] mem_addr,
  output logic [35:0] mem_data,
  output logic [1:0]  mem_half_en,
  output logic        mem_we,
  output logic        dropped,
  output logic        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);
  localparam logic [10:0]      H_LIM   = 11'(H_ACTIVE);
  localparam logic [9:0]       V_LIM   = 10'(V_ACTIVE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  typedef struct packed {
    logic [17:0] pix;
    logic [9:0]  x;
    logic [8:0]  y;
  } entry_t;

  // Word address of a pixel: two pixels per word, 320 words per row.
  function automatic logic [18:0] word_addr(input logic [9:0] x, input logic [8:0] y);
    return (19'(y) * 19'd320) + 19'(x[9:1]);
  endfunction

  entry_t fifo_q [DEPTH];

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             mem_req_q, mem_req_d;
  logic [18:0]      mem_addr_q, mem_addr_d;
  logic [35:0]      mem_data_q, mem_data_d;
  logic [1:0]       mem_half_en_q, mem_half_en_d;
  logic             pop2_q, pop2_d;
  logic             dropped_q, dropped_d;
  logic             overflow_q, overflow_d;

  logic             accept;
  logic             in_range;
  logic             push;
  logic [1:0]       pop_n;
  logic [PTR_W-1:0] rd_ptr_nxt;
  entry_t           head;
  entry_t           second;
  logic             can_merge;

  // Accept/range decode and FIFO head view; ptflag comes only from the count flop.
  always_comb begin
    ptflag     = (count_q < DEPTH_C);
    accept     = pt_wr & ptflag;
    in_range   = ({1'b0, pt_x} < H_LIM) && ({1'b0, pt_y} < V_LIM);
    push       = accept & in_range;
    rd_ptr_nxt = rd_ptr_q + PTR_W'(1);
    head       = fifo_q[rd_ptr_q];
    second     = fifo_q[rd_ptr_nxt];
    can_merge  = (count_q >= TWO_C) && !head.x[0] &&
                 (second.y == head.y) && (second.x == head.x + 10'd1);
  end

  // Drain FSM: latch the head (or a merged pair) in IDLE, hold it in REQ until granted.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    mem_half_en_d = mem_half_en_q;
    pop2_d        = pop2_q;
    pop_n         = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d    = S_REQ;
          mem_req_d  = 1'b1;
          mem_addr_d = word_addr(head.x, head.y);
          if (can_merge) begin
            mem_data_d    = {head.pix, second.pix};
            mem_half_en_d = 2'b11;
            pop2_d        = 1'b1;
          end else if (head.x[0]) begin
            mem_data_d    = {18'd0, head.pix};
            mem_half_en_d = 2'b01;
            pop2_d        = 1'b0;
          end else begin
            mem_data_d    = {head.pix, 18'd0};
            mem_half_en_d = 2'b10;
            pop2_d        = 1'b0;
          end
        end
      end
      S_REQ: begin
        if (mem_grant) begin
          state_d   = S_IDLE;
          mem_req_d = 1'b0;
          pop_n     = pop2_q ? 2'd2 : 2'd1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Pointer/count bookkeeping and status flags; push and pop may coincide.
  always_comb begin
    wr_ptr_d   = wr_ptr_q + PTR_W'(push);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_n);
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop_n);
    dropped_d  = accept & ~in_range;
    overflow_d = overflow_q | (pt_wr & ~ptflag);
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      mem_half_en_q <= '0;
      pop2_q        <= 1'b0;
      dropped_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      mem_half_en_q <= mem_half_en_d;
      pop2_q        <= pop2_d;
      dropped_q     <= dropped_d;
      overflow_q    <= overflow_d;
    end
  end

  // FIFO storage; contents are meaningless while count says the slot is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {pt_pixel_write, pt_x, pt_y};
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_half_en = mem_half_en_q;
  assign mem_we      = mem_req_q & mem_grant;
  assign dropped     = dropped_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_pt_write_port.sv
// Bench for pt_write_port: a pixel scoreboard checks every memory write,
// a vector table covers single-pixel placement and range drops, and directed
// sequences cover merging, backpressure and reset during a pending write.
module tb_pt_write_port;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [17:0] pt_pixel_write;
  logic [9:0]  pt_x;
  logic [8:0]  pt_y;
  logic        pt_wr;
  logic        ptflag;
  logic        mem_req;
  logic        mem_grant;
  logic [18:0] mem_addr;
  logic [35:0] mem_data;
  logic [1:0]  mem_half_en;
  logic        mem_we;
  logic        dropped;
  logic        overflow;

  always #5 clk = ~clk;

  pt_write_port #(.DEPTH(DEPTH), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
    .clk(clk), .reset_n(reset_n), .pt_pixel_write(pt_pixel_write),
    .pt_x(pt_x), .pt_y(pt_y), .pt_wr(pt_wr), .ptflag(ptflag),
    .mem_req(mem_req), .mem_grant(mem_grant), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_half_en(mem_half_en), .mem_we(mem_we),
    .dropped(dropped), .overflow(overflow)
  );

  typedef struct {
    logic [17:0] pix;
    logic [9:0]  x;
    logic [8:0]  y;
  } px_t;

  typedef struct {
    logic [17:0] pix;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        drop;
    logic [18:0] addr;
    logic [35:0] data;
    logic [1:0]  half;
  } vec_t;

  px_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        exp_drop, exp_ovf;
  int          wr_cnt, acc_cnt;
  logic [18:0] w_addr;
  logic [35:0] w_data;
  logic [1:0]  w_half;
  logic        s_req, s_ptflag, s_dropped, s_ovf;
  logic [18:0] s_addr;
  logic [35:0] s_data;
  logic [1:0]  s_half;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int exp_addr(input px_t p);
    return int'(p.y) * 320 + int'(p.x) / 2;
  endfunction

  // Sampled at the falling edge: checks flags, retires writes against the queue,
  // then records what the coming rising edge should do.
  task automatic monitor();
    px_t  a, b;
    logic model_flag, inr;
    s_req = mem_req; s_addr = mem_addr; s_data = mem_data; s_half = mem_half_en;
    s_ptflag = ptflag; s_dropped = dropped; s_ovf = overflow;
    if (!reset_n) begin
      exp_q.delete();
      exp_drop = 1'b0;
      exp_ovf  = 1'b0;
      return;
    end
    model_flag = (exp_q.size() < DEPTH);
    chk("ptflag", 64'(ptflag), 64'(model_flag));
    chk("dropped", 64'(dropped), 64'(exp_drop));
    chk("overflow", 64'(overflow), 64'(exp_ovf));
    if (mem_we) begin
      wr_cnt++;
      w_addr = mem_addr; w_data = mem_data; w_half = mem_half_en;
      chk("wr_has_pending", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        a = exp_q.pop_front();
        case (mem_half_en)
          2'b10: begin
            chk("wr_hi_even_x", 64'(a.x[0]), 64'(0));
            chk("wr_hi_addr", 64'(mem_addr), 64'(exp_addr(a)));
            chk("wr_hi_data", 64'(mem_data[35:18]), 64'(a.pix));
          end
          2'b01: begin
            chk("wr_lo_odd_x", 64'(a.x[0]), 64'(1));
            chk("wr_lo_addr", 64'(mem_addr), 64'(exp_addr(a)));
            chk("wr_lo_data", 64'(mem_data[17:0]), 64'(a.pix));
          end
          2'b11: begin
            chk("wr_pair_has_two", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
              b = exp_q.pop_front();
              chk("wr_pair_even_x", 64'(a.x[0]), 64'(0));
              chk("wr_pair_adjacent", 64'(b.x), 64'(a.x + 10'd1));
              chk("wr_pair_same_row", 64'(b.y), 64'(a.y));
              chk("wr_pair_addr", 64'(mem_addr), 64'(exp_addr(a)));
              chk("wr_pair_data", 64'(mem_data), 64'({a.pix, b.pix}));
            end
          end
          default: chk("wr_half_en_valid", 64'(mem_half_en), 64'(3));
        endcase
      end
    end
    inr = (int'(pt_x) < 640) && (int'(pt_y) < 480);
    exp_drop = pt_wr && model_flag && !inr;
    if (pt_wr && !model_flag) exp_ovf = 1'b1;
    if (pt_wr && model_flag) acc_cnt++;
    if (pt_wr && model_flag && inr) exp_q.push_back('{pt_pixel_write, pt_x, pt_y});
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [17:0] pix, input int x, input int y);
    pt_pixel_write = pix;
    pt_x = 10'(x);
    pt_y = 9'(y);
    pt_wr = 1'b1;
  endtask

  task automatic wait_we(input int budget, input string name);
    int start;
    int n;
    start = wr_cnt;
    n = 0;
    while (wr_cnt == start && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_write_seen"}, 64'(wr_cnt != start), 64'(1));
  endtask

  task automatic drain(input int budget, input string name);
    int n;
    n = 0;
    pt_wr = 1'b0;
    mem_grant = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];

  initial begin
    int acc0, wr0, px, py, nx, ny;
    reset_n = 1'b0; pt_wr = 1'b0; pt_pixel_write = '0; pt_x = '0; pt_y = '0;
    mem_grant = 1'b0; wr_cnt = 0; acc_cnt = 0; exp_drop = 1'b0; exp_ovf = 1'b0;

    tbl[0] = '{18'h2ABCD, 10'd5,    9'd2,   1'b0, 19'd642,    36'h00002ABCD, 2'b01};
    tbl[1] = '{18'h3FFFF, 10'd0,    9'd0,   1'b0, 19'd0,      36'hFFFFC0000, 2'b10};
    tbl[2] = '{18'h12345, 10'd639,  9'd479, 1'b0, 19'd153599, 36'h000012345, 2'b01};
    tbl[3] = '{18'h00001, 10'd638,  9'd0,   1'b0, 19'd319,    36'h000040000, 2'b10};
    tbl[4] = '{18'h15555, 10'd100,  9'd200, 1'b0, 19'd64050,  36'h555540000, 2'b10};
    tbl[5] = '{18'h11111, 10'd640,  9'd0,   1'b1, 19'd0,      36'h0,         2'b00};
    tbl[6] = '{18'h22222, 10'd0,    9'd480, 1'b1, 19'd0,      36'h0,         2'b00};
    tbl[7] = '{18'h33333, 10'd1023, 9'd511, 1'b1, 19'd0,      36'h0,         2'b00};

    repeat (2) tick();
    chk("rst_ptflag", 64'(ptflag), 64'(1));
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_data", 64'(mem_data), 64'(0));
    chk("rst_half_en", 64'(mem_half_en), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    reset_n = 1'b1;
    tick();

    // Table: single pixels with grant held high, plus out-of-range drops.
    mem_grant = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].pix, int'(tbl[i].x), int'(tbl[i].y));
      tick();
      pt_wr = 1'b0;
      tick();
      chk($sformatf("tbl%0d_dropped", i), 64'(s_dropped), 64'(tbl[i].drop));
      if (tbl[i].drop) begin
        wr0 = wr_cnt;
        repeat (3) tick();
        chk($sformatf("tbl%0d_no_req", i), 64'(s_req), 64'(0));
        chk($sformatf("tbl%0d_no_write", i), 64'(wr_cnt - wr0), 64'(0));
      end else begin
        wait_we(10, $sformatf("tbl%0d", i));
        chk($sformatf("tbl%0d_addr", i), 64'(w_addr), 64'(tbl[i].addr));
        chk($sformatf("tbl%0d_data", i), 64'(w_data), 64'(tbl[i].data));
        chk($sformatf("tbl%0d_half", i), 64'(w_half), 64'(tbl[i].half));
        tick();
        chk($sformatf("tbl%0d_idle_ptflag", i), 64'(s_ptflag), 64'(1));
      end
    end

    // A neighbour arriving after the head was latched is written separately.
    mem_grant = 1'b0;
    drive(18'h11111, 10, 3); tick();
    drive(18'h22222, 11, 3); tick();
    pt_wr = 1'b0;
    repeat (3) tick();
    chk("late_req", 64'(s_req), 64'(1));
    chk("late_hold_addr", 64'(s_addr), 64'(965));
    chk("late_hold_half", 64'(s_half), 64'(2'b10));
    chk("late_hold_data", 64'(s_data), 64'(36'h444440000));
    mem_grant = 1'b1;
    wait_we(10, "late_first");
    chk("late_first_half", 64'(w_half), 64'(2'b10));
    wait_we(10, "late_second");
    chk("late_second_addr", 64'(w_addr), 64'(965));
    chk("late_second_half", 64'(w_half), 64'(2'b01));
    chk("late_second_data", 64'(w_data), 64'(36'h000022222));

    // Both halves queued behind a pending write merge into one word.
    mem_grant = 1'b0;
    drive(18'h3AAAA, 0, 0); tick();
    drive(18'h11111, 10, 3); tick();
    drive(18'h22222, 11, 3); tick();
    pt_wr = 1'b0;
    repeat (2) tick();
    chk("merge_block_req", 64'(s_req), 64'(1));
    chk("merge_block_addr", 64'(s_addr), 64'(0));
    mem_grant = 1'b1;
    wait_we(10, "merge_block");
    chk("merge_block_w_addr", 64'(w_addr), 64'(0));
    wait_we(10, "merge_pair");
    chk("merge_pair_addr", 64'(w_addr), 64'(965));
    chk("merge_pair_half", 64'(w_half), 64'(2'b11));
    chk("merge_pair_data", 64'(w_data), 64'(36'h444462222));
    tick();

    // Backpressure: grant low for 20 cycles with pt_wr high every cycle.
    mem_grant = 1'b0;
    acc0 = acc_cnt;
    for (int k = 0; k < 20; k++) begin
      drive(18'(32'h100 + k), 100 + k, 10);
      tick();
    end
    pt_wr = 1'b0;
    chk("bp_accepts", 64'(acc_cnt - acc0), 64'(DEPTH));
    chk("bp_ptflag_low", 64'(s_ptflag), 64'(0));
    chk("bp_overflow", 64'(s_ovf), 64'(1));
    drain(60, "bp");
    tick();
    chk("bp_ptflag_back", 64'(s_ptflag), 64'(1));

    // Reset while a write is pending with three entries queued.
    mem_grant = 1'b0;
    drive(18'h0AAAA, 20, 5); tick();
    drive(18'h0BBBB, 22, 5); tick();
    drive(18'h0CCCC, 24, 5); tick();
    pt_wr = 1'b0;
    tick();
    chk("rq_pre_req", 64'(mem_req), 64'(1));
    #2;
    reset_n = 1'b0;
    mem_grant = 1'b1;
    #1;
    chk("rq_req_cleared", 64'(mem_req), 64'(0));
    chk("rq_no_we", 64'(mem_we), 64'(0));
    chk("rq_addr_cleared", 64'(mem_addr), 64'(0));
    chk("rq_data_cleared", 64'(mem_data), 64'(0));
    chk("rq_half_cleared", 64'(mem_half_en), 64'(0));
    chk("rq_ptflag", 64'(ptflag), 64'(1));
    chk("rq_overflow", 64'(overflow), 64'(0));
    tick();
    wr0 = wr_cnt;
    reset_n = 1'b1;
    drive(18'h0F0F0, 7, 7);
    tick();
    pt_wr = 1'b0;
    wait_we(10, "post_rst");
    chk("post_rst_addr", 64'(w_addr), 64'(2243));
    chk("post_rst_half", 64'(w_half), 64'(2'b01));
    chk("post_rst_data", 64'(w_data), 64'(36'h00000F0F0));
    chk("post_rst_one_write", 64'(wr_cnt - wr0), 64'(1));
    tick();

    // Random traffic with random grants; the scoreboard checks every write.
    px = 0; py = 0;
    for (int c = 0; c < 10000; c++) begin
      mem_grant = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 99) < 5) begin
        nx = int'($urandom_range(640, 1023));
        ny = int'($urandom_range(0, 511));
      end else if ($urandom_range(0, 1) == 1 && px < 639) begin
        nx = px + 1;
        ny = py;
        px = nx;
      end else begin
        nx = int'($urandom_range(0, 639));
        ny = int'($urandom_range(0, 479));
        px = nx;
        py = ny;
      end
      drive(18'($urandom), nx, ny);
      pt_wr = ($urandom_range(0, 99) < 60);
      tick();
    end
    drain(200, "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
